// File: rtl/pea_ofm_pack.sv
// -----------------------------------------------------------------------------
// pea_ofm_pack
//   Output stage behind the 3x3 PE array. Each incoming result vector has its
//   valid lanes requantized to int8 and packed into the low bytes of one word.
//   Requantization per lane is round half up, arithmetic right shift, optional
//   ReLU, then saturation. Packed words are buffered in a small FIFO and drained
//   to the OFM write-back over a valid/ready handshake.
//
//   The PE array cannot be stalled. Stage 1 holds its word while the FIFO is
//   full. A vector that arrives while stage 1 is blocked is dropped, and the
//   sticky ovf_err flag is set.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   sum_valid, sum     per-lane valid and signed sums from the PE array
//   cfg_shift/relu     requant shift amount and ReLU enable, sampled per vector
//   clr_err            clears ovf_err (a set in the same cycle wins)
//   ofm_valid/ready    output handshake
//   ofm_data, ofm_cnt  packed int8 bytes and number of valid bytes
//   ovf_err            sticky drop flag
//   busy               stage 1 or the FIFO holds data
// -----------------------------------------------------------------------------
module pea_ofm_pack #(
    parameter int COL       = 8,
    parameter int OFM_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [COL-1:0]             sum_valid,
    input  logic [COL*OFM_WIDTH-1:0]   sum,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_relu,
    input  logic                       clr_err,
    output logic                       ofm_valid,
    input  logic                       ofm_ready,
    output logic [COL*8-1:0]           ofm_data,
    output logic [$clog2(COL+1)-1:0]   ofm_cnt,
    output logic                       ovf_err,
    output logic                       busy
);

    localparam int CW = $clog2(COL + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = COL * 8;

    localparam logic signed [OFM_WIDTH:0] S8_MAX = (OFM_WIDTH + 1)'(127);
    localparam logic signed [OFM_WIDTH:0] S8_MIN = (OFM_WIDTH + 1)'(-128);

    // Round half up and shift, using one extra bit so that the bias cannot wrap.
    function automatic logic signed [OFM_WIDTH:0] round_shift(
        input logic signed [OFM_WIDTH-1:0] x,
        input logic        [4:0]           sh
    );
        logic signed [OFM_WIDTH:0] xe;
        logic signed [OFM_WIDTH:0] bias;
        xe   = {x[OFM_WIDTH-1], x};
        bias = (OFM_WIDTH + 1)'(1) << (sh - 5'd1);
        if (sh == 5'd0) begin
            return xe;
        end
        return (xe + bias) >>> sh;
    endfunction

    // Apply the optional ReLU, then saturate to int8.
    function automatic logic [7:0] relu_sat(
        input logic signed [OFM_WIDTH:0] r,
        input logic                      relu
    );
        if (relu && r[OFM_WIDTH]) begin
            return 8'h00;
        end
        if (r > S8_MAX) begin
            return 8'h7F;
        end
        if (r < S8_MIN) begin
            return 8'h80;
        end
        return r[7:0];
    endfunction

    // ---- stage 0: quantize and compact the incoming vector (combinational) ----
    logic [WW-1:0] word_p0;
    logic [CW-1:0] cnt_p0;
    logic          vld_p0;

    assign vld_p0 = |sum_valid;

    always_comb begin
        word_p0 = '0;
        cnt_p0  = '0;
        for (int j = 0; j < COL; j++) begin
            if (sum_valid[j]) begin
                word_p0[cnt_p0*8 +: 8] =
                    relu_sat(round_shift(sum[j*OFM_WIDTH +: OFM_WIDTH], cfg_shift), cfg_relu);
                cnt_p0 = cnt_p0 + CW'(1);
            end
        end
    end

    // ---- stage 1: one-word register feeding the FIFO ----
    logic [WW-1:0] word_p1;
    logic [CW-1:0] cnt_p1;
    logic          vld_p1;

    logic [AW:0]   fifo_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          s1_free;
    logic          load_p1;
    logic          drop;

    assign pop     = ofm_valid && ofm_ready;
    // Writing into a full FIFO is allowed only when the head leaves in the same cycle.
    assign push    = vld_p1 && ((fifo_cnt != (AW + 1)'(DEPTH)) || pop);
    assign s1_free = !vld_p1 || push;
    assign load_p1 = vld_p0 && s1_free;
    assign drop    = vld_p0 && !s1_free;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= load_p1 || (vld_p1 && !push);
        end
    end

    always_ff @(posedge clk) begin
        if (load_p1) begin
            word_p1 <= word_p0;
            cnt_p1  <= cnt_p0;
        end
    end

    // ---- stage 2: FIFO storage; the head is presented on the output ----
    logic [WW-1:0] mem_data [DEPTH];
    logic [CW-1:0] mem_cnt  [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= word_p1;
            mem_cnt[wr_ptr]  <= cnt_p1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt <= fifo_cnt + (AW + 1)'(push) - (AW + 1)'(pop);
            if (drop) begin
                ovf_err <= 1'b1;
            end else if (clr_err) begin
                ovf_err <= 1'b0;
            end
        end
    end

    // When the FIFO is empty the outputs are forced to zero, so no stale entry is shown.
    assign ofm_valid = (fifo_cnt != '0);
    assign ofm_data  = ofm_valid ? mem_data[rd_ptr] : '0;
    assign ofm_cnt   = ofm_valid ? mem_cnt[rd_ptr]  : '0;
    assign busy      = vld_p1 || ofm_valid;

endmodule
